riscv_jtag_dtm_0p11: RTL and testbench

JTAG Debug Transport Module per RISC-V External Debug Support v0.11, directly upstream of the Debug Module. It implements the IEEE 1149.1 TAP controller, the instruction register and the IDCODE/DTMCONTROL/DBUS/BYPASS data registers. It converts completed DBUS scans into 41-bit DMI requests and returns 36-bit DMI responses to the next DBUS capture. It runs entirely in the TCK domain; the Debug Module's CDC stages absorb the crossing.

---
 rtl/riscv_jtag_dtm_0p11.sv | 181 ++++++++++++++++++
 tb/tb_riscv_jtag_dtm_0p11.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_jtag_dtm_0p11.sv
// Purpose: RISC-V debug 0.11 JTAG DTM: TAP controller, IR, IDCODE/DTMCONTROL/DBUS/BYPASS DRs, DMI bridge.
// Latency: dtm_req_valid rises one TCK after Update-DR; tdo/tdo_oe update on the falling TCK edge.
// Backpressure: request held stable until dtm_req_ready; a DBUS update while busy is dropped and sets sticky dbusstat=3.
// Ports: clk/rst_n (TCK, async active-low TRST_n/POR); tms/tdi/tdo/tdo_oe (JTAG pins);
//        dtm_req_* 41-bit {addr,data,op} request out; dtm_resp_* 36-bit {data,resp} response in.
// Option: define RISCV_DTM_IDCODE_EN to include the IDCODE register; without it the IR resets to BYPASS (0x1F).
module riscv_jtag_dtm_0p11 #(
    parameter logic [31:0] IDCODE      = 32'h1000_0A6D,
    parameter logic [2:0]  IDLE_CYCLES = 3'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tms,
    input  logic        tdi,
    output logic        tdo,
    output logic        tdo_oe,
    output logic        dtm_req_valid,
    input  logic        dtm_req_ready,
    output logic [40:0] dtm_req_bits,
    input  logic        dtm_resp_valid,
    output logic        dtm_resp_ready,
    input  logic [35:0] dtm_resp_bits
);
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_e;

    typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_DTMCS, SEL_DBUS} dr_sel_e;

    localparam logic [4:0] IR_DTMCS = 5'h10;
    localparam logic [4:0] IR_DBUS  = 5'h11;
`ifdef RISCV_DTM_IDCODE_EN
    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_RESET  = IR_IDCODE;
`else
    localparam logic [4:0] IR_RESET  = 5'h1F;
`endif

    tap_e        tap_q;
    logic [4:0]  ir_q, ir_sr_q;
    logic [40:0] dr_q;
    logic        tdo_q, tdo_oe_q;
    logic        req_vld_q, busy_q;
    logic [40:0] req_bits_q;
    logic [1:0]  dbusstat_q, last_resp_q;
    logic [4:0]  last_addr_q;
    logic [33:0] last_data_q;

    dr_sel_e     dr_sel;
    logic [1:0]  dbus_status;
    logic [31:0] dtmcs_rd;
    logic        req_hs, resp_hs, busy_eff, dbus_upd, dtmcs_upd;

    always_comb begin
        dr_sel = SEL_BYPASS;
        case (ir_q)
`ifdef RISCV_DTM_IDCODE_EN
            IR_IDCODE: dr_sel = SEL_IDCODE;
`endif
            IR_DTMCS:  dr_sel = SEL_DTMCS;
            IR_DBUS:   dr_sel = SEL_DBUS;
            default:   dr_sel = SEL_BYPASS;
        endcase
    end

    // Busy dominates, then the sticky error, then the last DM response code.
    assign dbus_status = busy_q ? 2'd3 : ((dbusstat_q != 2'd0) ? dbusstat_q : last_resp_q);
    assign dtmcs_rd    = {15'b0, 1'b0, 3'b0, IDLE_CYCLES, dbusstat_q, 4'd5, 4'd0};

    assign req_hs    = req_vld_q & dtm_req_ready;
    assign dtm_resp_ready = busy_q & ~req_vld_q;
    assign resp_hs   = dtm_resp_ready & dtm_resp_valid;
    // A response landing on the same edge as a DBUS update retires first.
    assign busy_eff  = busy_q & ~resp_hs;
    assign dbus_upd  = (tap_q == UPD_DR) && (dr_sel == SEL_DBUS);
    assign dtmcs_upd = (tap_q == UPD_DR) && (dr_sel == SEL_DTMCS);

    // TAP state, instruction register and data shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q   <= TLR;
            ir_q    <= IR_RESET;
            ir_sr_q <= '0;
            dr_q    <= '0;
        end else begin
            case (tap_q)
                TLR:    tap_q <= tms ? TLR    : RTI;
                RTI:    tap_q <= tms ? SEL_DR : RTI;
                SEL_DR: tap_q <= tms ? SEL_IR : CAP_DR;
                CAP_DR: tap_q <= tms ? EX1_DR : SH_DR;
                SH_DR:  tap_q <= tms ? EX1_DR : SH_DR;
                EX1_DR: tap_q <= tms ? UPD_DR : PAU_DR;
                PAU_DR: tap_q <= tms ? EX2_DR : PAU_DR;
                EX2_DR: tap_q <= tms ? UPD_DR : SH_DR;
                UPD_DR: tap_q <= tms ? SEL_DR : RTI;
                SEL_IR: tap_q <= tms ? TLR    : CAP_IR;
                CAP_IR: tap_q <= tms ? EX1_IR : SH_IR;
                SH_IR:  tap_q <= tms ? EX1_IR : SH_IR;
                EX1_IR: tap_q <= tms ? UPD_IR : PAU_IR;
                PAU_IR: tap_q <= tms ? EX2_IR : PAU_IR;
                EX2_IR: tap_q <= tms ? UPD_IR : SH_IR;
                UPD_IR: tap_q <= tms ? SEL_DR : RTI;
                default: tap_q <= TLR;
            endcase

            case (tap_q)
                TLR:    ir_q    <= IR_RESET;
                CAP_IR: ir_sr_q <= 5'b00001;
                SH_IR:  ir_sr_q <= {tdi, ir_sr_q[4:1]};
                UPD_IR: ir_q    <= ir_sr_q;
                CAP_DR: begin
                    case (dr_sel)
                        SEL_IDCODE: dr_q <= {9'b0, IDCODE};
                        SEL_DTMCS:  dr_q <= {9'b0, dtmcs_rd};
                        SEL_DBUS:   dr_q <= {last_addr_q, last_data_q, dbus_status};
                        default:    dr_q[0] <= 1'b0;
                    endcase
                end
                // tdi enters at the MSB of the selected register length.
                SH_DR: begin
                    case (dr_sel)
                        SEL_BYPASS: dr_q[0]    <= tdi;
                        SEL_DBUS:   dr_q       <= {tdi, dr_q[40:1]};
                        default:    dr_q[31:0] <= {tdi, dr_q[31:1]};
                    endcase
                end
                default: ;
            endcase
        end
    end

    // tdo presents the current LSB half a cycle after each shift edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tdo_oe_q <= (tap_q == SH_IR) || (tap_q == SH_DR);
            if (tap_q == SH_IR)      tdo_q <= ir_sr_q[0];
            else if (tap_q == SH_DR) tdo_q <= dr_q[0];
            else                     tdo_q <= 1'b0;
        end
    end

    // DMI request/response bookkeeping; unaffected by Test-Logic-Reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_vld_q   <= 1'b0;
            req_bits_q  <= '0;
            busy_q      <= 1'b0;
            dbusstat_q  <= 2'd0;
            last_resp_q <= 2'd0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            if (req_hs) req_vld_q <= 1'b0;
            if (resp_hs) begin
                last_data_q <= dtm_resp_bits[35:2];
                last_resp_q <= dtm_resp_bits[1:0];
                last_addr_q <= req_bits_q[40:36];
                busy_q      <= 1'b0;
            end
            if (dbus_upd) begin
                if (busy_eff) begin
                    dbusstat_q <= 2'd3;
                end else if ((dbusstat_q == 2'd0) && ((dr_q[1:0] == 2'd1) || (dr_q[1:0] == 2'd2))) begin
                    req_vld_q  <= 1'b1;
                    req_bits_q <= dr_q;
                    busy_q     <= 1'b1;
                end
            end
            if (dtmcs_upd && dr_q[16]) dbusstat_q <= 2'd0;
        end
    end

    assign tdo           = tdo_q;
    assign tdo_oe        = tdo_oe_q;
    assign dtm_req_valid = req_vld_q;
    assign dtm_req_bits  = req_bits_q;
endmodule

// File: tb/tb_riscv_jtag_dtm_0p11.sv
module tb_riscv_jtag_dtm_0p11;
    logic        clk = 1'b0;
    logic        rst_n, tms, tdi, tdo, tdo_oe;
    logic        dtm_req_valid, dtm_req_ready, dtm_resp_valid, dtm_resp_ready;
    logic [40:0] dtm_req_bits;
    logic [35:0] dtm_resp_bits;

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level model of the DTM's DMI-facing state.
    bit          m_busy, req_pend;
    logic [1:0]  m_stat, m_resp;
    logic [4:0]  m_addr;
    logic [33:0] m_data;
    logic [40:0] m_req;
    logic        oe_shift;

    localparam logic [31:0] IDCODE_EXP = 32'h1000_0A6D;

    riscv_jtag_dtm_0p11 dut (
        .clk(clk), .rst_n(rst_n), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_oe(tdo_oe),
        .dtm_req_valid(dtm_req_valid), .dtm_req_ready(dtm_req_ready), .dtm_req_bits(dtm_req_bits),
        .dtm_resp_valid(dtm_resp_valid), .dtm_resp_ready(dtm_resp_ready), .dtm_resp_bits(dtm_resp_bits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dtmcs_exp(input logic [1:0] s);
        return {15'b0, 1'b0, 3'b0, 3'd5, s, 4'd5, 4'd0};
    endfunction

    function automatic logic [40:0] model_cap();
        logic [1:0] st;
        if (m_busy)              st = 2'd3;
        else if (m_stat != 2'd0) st = m_stat;
        else                     st = m_resp;
        return {m_addr, m_data, st};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; req_pend = 1'b0; m_stat = 2'd0; m_resp = 2'd0;
        m_addr = '0; m_data = '0; m_req = '0;
    endtask

    task automatic model_resp(input logic [35:0] r);
        m_data = r[35:2]; m_resp = r[1:0]; m_addr = m_req[40:36]; m_busy = 1'b0;
    endtask

    task automatic model_update(input logic [1:0] op, input logic [4:0] a, input logic [33:0] d, output bit issued);
        issued = 1'b0;
        if (m_busy) m_stat = 2'd3;
        else if (m_stat == 2'd0 && (op == 2'd1 || op == 2'd2)) begin
            m_req = {a, d, op}; m_busy = 1'b1; issued = 1'b1;
        end
    endtask

    // One TCK: drive pins in the low phase, sample tdo as the host would at the rising edge.
    task automatic tck(input logic tms_v, input logic tdi_v, output logic tdo_v);
        tms = tms_v; tdi = tdi_v;
        tdo_v = tdo;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic reset_tap();
        logic o;
        for (int i = 0; i < 5; i++) tck(1'b1, 1'b0, o);
        tck(1'b0, 1'b0, o);
    endtask

    task automatic shift_ir(input logic [4:0] ir, output logic [4:0] cap);
        logic o;
        tck(1'b1, 1'b0, o); tck(1'b1, 1'b0, o); tck(1'b0, 1'b0, o); tck(1'b0, 1'b0, o);
        for (int i = 0; i < 5; i++) begin
            tck(i == 4, ir[i], o);
            cap[i] = o;
        end
        tck(1'b1, 1'b0, o); tck(1'b0, 1'b0, o);
    endtask

    task automatic shift_dr(input int n, input logic [63:0] din, input bit resp_upd,
                            input logic [35:0] rbits, output logic [63:0] dout);
        logic o;
        dout = '0;
        tck(1'b1, 1'b0, o); tck(1'b0, 1'b0, o); tck(1'b0, 1'b0, o);
        for (int i = 0; i < n; i++) begin
            if (i == 0) oe_shift = tdo_oe;
            tck(i == n - 1, din[i], o);
            dout[i] = o;
        end
        tck(1'b1, 1'b0, o);
        if (resp_upd) begin dtm_resp_valid = 1'b1; dtm_resp_bits = rbits; end
        tck(1'b0, 1'b0, o);
        dtm_resp_valid = 1'b0;
    endtask

    task automatic dtmcs_scan(input logic [31:0] din);
        logic [63:0] dout;
        logic [31:0] exp;
        exp = dtmcs_exp(m_stat);
        shift_dr(32, {32'b0, din}, 1'b0, '0, dout);
        chk("dtmcs_read", 64'(dout[31:0]), 64'(exp));
        if (din[16]) m_stat = 2'd0;
    endtask

    task automatic dbus_scan(input logic [1:0] op, input logic [4:0] a, input logic [33:0] d,
                             input bit sim, input logic [35:0] r, output logic [40:0] cap);
        logic [63:0] dout;
        logic [40:0] exp_cap;
        bit issued;
        exp_cap = model_cap();
        shift_dr(41, {23'b0, a, d, op}, sim, r, dout);
        cap = dout[40:0];
        chk("dbus_capture", 64'(cap), 64'(exp_cap));
        if (sim) model_resp(r);
        model_update(op, a, d, issued);
        if (issued) req_pend = 1'b1;
        chk("dbus_req_valid", 64'(dtm_req_valid), 64'(req_pend));
        if (issued) chk("dbus_req_bits", 64'(dtm_req_bits), 64'(m_req));
        chk("dbus_resp_ready", 64'(dtm_resp_ready), 64'(m_busy && !req_pend));
    endtask

    task automatic accept_req(input int stall);
        logic o;
        for (int k = 0; k < stall; k++) begin
            tck(1'b0, 1'b0, o);
            chk("req_hold_valid", 64'(dtm_req_valid), 64'd1);
            chk("req_hold_bits", 64'(dtm_req_bits), 64'(m_req));
        end
        dtm_req_ready = 1'b1;
        tck(1'b0, 1'b0, o);
        dtm_req_ready = 1'b0;
        req_pend = 1'b0;
        chk("req_drop", 64'(dtm_req_valid), 64'd0);
        chk("resp_ready_up", 64'(dtm_resp_ready), 64'd1);
    endtask

    task automatic respond(input logic [35:0] r);
        logic o;
        dtm_resp_valid = 1'b1; dtm_resp_bits = r;
        tck(1'b0, 1'b0, o);
        dtm_resp_valid = 1'b0;
        model_resp(r);
        chk("resp_ready_down", 64'(dtm_resp_ready), 64'd0);
    endtask

    task automatic check_reset_ir(input string tag);
        logic [63:0] din, dout;
        din = {32'b0, $urandom()};
        shift_dr(32, din, 1'b0, '0, dout);
`ifdef RISCV_DTM_IDCODE_EN
        chk(tag, 64'(dout[31:0]), 64'(IDCODE_EXP));
`else
        chk(tag, 64'(dout[31:0]), 64'({din[30:0], 1'b0}));
`endif
    endtask

    initial begin : main
        logic        o;
        logic [4:0]  cap5, ir_r;
        logic [40:0] cap41;
        logic [63:0] dout, din, rw, rw2;

        rst_n = 1'b0; tms = 1'b1; tdi = 1'b0;
        dtm_req_ready = 1'b0; dtm_resp_valid = 1'b0; dtm_resp_bits = '0;
        model_reset();
        @(negedge clk); #1;
        chk("rst_tdo", 64'(tdo), 64'd0);
        chk("rst_tdo_oe", 64'(tdo_oe), 64'd0);
        chk("rst_req_valid", 64'(dtm_req_valid), 64'd0);
        chk("rst_req_bits", 64'(dtm_req_bits), 64'd0);
        chk("rst_resp_ready", 64'(dtm_resp_ready), 64'd0);
        rst_n = 1'b1;
        tck(1'b0, 1'b0, o);
        check_reset_ir("dr_after_reset");

        // BYPASS: 0xA5 comes back one clock late behind the captured 0.
        shift_ir(5'h1F, cap5);
        chk("ir_capture", 64'(cap5), 64'd1);
        shift_dr(9, {55'b0, 1'b0, 8'hA5}, 1'b0, '0, dout);
        chk("bypass_a5", 64'(dout[8:0]), 64'({8'hA5, 1'b0}));
        chk("tdo_oe_shift", 64'(oe_shift), 64'd1);
        chk("tdo_oe_idle", 64'(tdo_oe), 64'd0);
        ir_r = 5'($urandom_range(2, 15));
        shift_ir(ir_r, cap5);
        din = {48'b0, 16'($urandom())};
        shift_dr(17, din, 1'b0, '0, dout);
        chk("bypass_rand", 64'(dout[16:0]), 64'({din[15:0], 1'b0}));

        shift_ir(5'h10, cap5);
        dtmcs_scan(32'h0);

        // Directed DBUS write, stalled request, response, read-back.
        shift_ir(5'h11, cap5);
        dbus_scan(2'd2, 5'h10, 34'h4, 1'b0, '0, cap41);
        chk("dir_req_bits", 64'(dtm_req_bits), 64'({5'h10, 34'h4, 2'd2}));
        accept_req(3);
        respond({34'h4, 2'd0});
        dbus_scan(2'd0, 5'h0, 34'h0, 1'b0, '0, cap41);
        chk("dir_readback", 64'(cap41), 64'({5'h10, 34'h4, 2'd0}));

        // Update while busy: dropped, sticky status 3 until cleared through DTMCONTROL.
        dbus_scan(2'd1, 5'h03, 34'h0, 1'b0, '0, cap41);
        accept_req(0);
        dbus_scan(2'd1, 5'h04, 34'h0, 1'b0, '0, cap41);
        chk("busy_no_req", 64'(dtm_req_valid), 64'd0);
        respond({34'h155, 2'd0});
        dbus_scan(2'd1, 5'h05, 34'h0, 1'b0, '0, cap41);
        chk("sticky_status", 64'(cap41[1:0]), 64'd3);
        chk("sticky_no_req", 64'(dtm_req_valid), 64'd0);
        shift_ir(5'h10, cap5);
        dtmcs_scan(32'h0001_0000);
        dtmcs_scan(32'h0);
        shift_ir(5'h11, cap5);
        dbus_scan(2'd1, 5'h06, 34'h0, 1'b0, '0, cap41);
        chk("req_after_clear", 64'(dtm_req_valid), 64'd1);
        accept_req(1);

        // Response and DBUS update on the same edge: response retires, new request issues.
        dbus_scan(2'd2, 5'h07, 34'h2_0000_0001, 1'b1, {34'h3_0000_0002, 2'd2}, cap41);
        chk("sim_new_req", 64'(dtm_req_valid), 64'd1);
        accept_req(0);
        respond({34'h1, 2'd0});

        for (int it = 0; it < 40; it++) begin
            bit sim;
            rw = {$urandom(), $urandom()};
            rw2 = {$urandom(), $urandom()};
            if (m_stat != 2'd0 && $urandom_range(0, 2) == 0) begin
                shift_ir(5'h10, cap5);
                dtmcs_scan(32'h0001_0000);
                shift_ir(5'h11, cap5);
                chk("rnd_ir_capture", 64'(cap5), 64'd1);
            end
            sim = m_busy && !req_pend && ($urandom_range(0, 3) == 0);
            dbus_scan(rw[1:0], rw[6:2], rw[40:7], sim, rw2[35:0], cap41);
            if (req_pend && $urandom_range(0, 3) != 0) accept_req($urandom_range(0, 2));
            if (m_busy && !req_pend && $urandom_range(0, 1) == 0) respond(rw2[63:28]);
        end
        if (req_pend) accept_req(0);
        if (m_busy) respond(36'h9_8765_4321);
        if (m_stat != 2'd0) begin
            shift_ir(5'h10, cap5);
            dtmcs_scan(32'h0001_0000);
        end

        // Five tms=1 clocks reach Test-Logic-Reset from anywhere.
        shift_ir(5'h10, cap5);
        for (int i = 0; i < 7; i++) tck(1'($urandom_range(0, 1)), 1'b0, o);
        reset_tap();
        check_reset_ir("dr_after_tms_reset");

        // Async reset with a request outstanding.
        shift_ir(5'h11, cap5);
        dbus_scan(2'd1, 5'h1A, 34'h0, 1'b0, '0, cap41);
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", 64'(dtm_req_valid), 64'd0);
        chk("arst_req_bits", 64'(dtm_req_bits), 64'd0);
        chk("arst_resp_ready", 64'(dtm_resp_ready), 64'd0);
        chk("arst_tdo_oe", 64'(tdo_oe), 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        tck(1'b0, 1'b0, o);
        check_reset_ir("dr_after_arst");
        shift_ir(5'h11, cap5);
        dbus_scan(2'd0, 5'h0, 34'h0, 1'b0, '0, cap41);
        chk("arst_dbus_clear", 64'(cap41), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
